// File: rtl/register_file_scoreboard_pkg.sv
// Shared write-pattern codes for the register file and its writeback formatter.
package register_file_scoreboard_pkg;
  localparam logic [2:0] REGISTER_WRITE_WORD          = 3'd0;
  localparam logic [2:0] REGISTER_WRITE_BYTE_UNSIGNED = 3'd1;
  localparam logic [2:0] REGISTER_WRITE_BYTE_SIGNED   = 3'd2;
  localparam logic [2:0] REGISTER_WRITE_HALF_UNSIGNED = 3'd3;
  localparam logic [2:0] REGISTER_WRITE_HALF_SIGNED   = 3'd4;
endpackage

// File: rtl/register_write_formatter.sv
// Turns raw writeback data into the XLEN value to store, per write pattern.
module register_write_formatter
  import register_file_scoreboard_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      pattern,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] formatted,
  output logic            legal
);
  always_comb begin
    formatted = '0;
    legal     = 1'b1;
    case (pattern)
      REGISTER_WRITE_WORD:          formatted = data;
      REGISTER_WRITE_BYTE_UNSIGNED: formatted = {{(XLEN-8){1'b0}}, data[7:0]};
      REGISTER_WRITE_BYTE_SIGNED:   formatted = {{(XLEN-8){data[7]}}, data[7:0]};
      REGISTER_WRITE_HALF_UNSIGNED: formatted = {{(XLEN-16){1'b0}}, data[15:0]};
      REGISTER_WRITE_HALF_SIGNED:   formatted = {{(XLEN-16){data[15]}}, data[15:0]};
      default:                      legal     = 1'b0;
    endcase
  end
endmodule

// File: rtl/register_file_scoreboard.sv
// Multi-port register file with formatted writeback, optional write bypass and
// a per-register pending scoreboard with a running pending count.
module register_file_scoreboard
  import register_file_scoreboard_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_address,
  output logic [NRD*XLEN-1:0] data_out,
  output logic [NRD-1:0]      rd_ready,
  input  logic                reserve_enable,
  input  logic [AW-1:0]       reserve_address,
  input  logic                wr_enable,
  input  logic [AW-1:0]       wr_address,
  input  logic [XLEN-1:0]     wr_data,
  input  logic [2:0]          write_pattern,
  output logic [AW:0]         pending_count
);
  logic [NREGS-1:0][XLEN-1:0] storage;
  logic [NREGS-1:0]           pending, pending_nxt;
  logic [AW:0]                count_nxt;
  logic [XLEN-1:0]            wr_fmt;
  logic                       wr_legal, wr_eff, rsv_eff, inc, dec;

  register_write_formatter #(.XLEN(XLEN)) u_fmt (
    .pattern   (write_pattern),
    .data      (wr_data),
    .formatted (wr_fmt),
    .legal     (wr_legal)
  );

  // x0 is hardwired: writes and reservations to it are dropped here.
  assign wr_eff  = wr_enable && wr_legal && (wr_address != '0);
  assign rsv_eff = reserve_enable && (reserve_address != '0);

  // Reserve is applied after the clear so a same-address reserve wins.
  assign inc = rsv_eff && !pending[reserve_address];
  assign dec = wr_eff && pending[wr_address] && !(rsv_eff && (reserve_address == wr_address));

  always_comb begin
    pending_nxt = pending;
    if (wr_eff)  pending_nxt[wr_address]      = 1'b0;
    if (rsv_eff) pending_nxt[reserve_address] = 1'b1;
  end

  assign count_nxt = pending_count + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      storage       <= '0;
      pending       <= '0;
      pending_count <= '0;
    end else begin
      if (wr_eff) storage[wr_address] <= wr_fmt;
      pending       <= pending_nxt;
      pending_count <= count_nxt;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    assign ra  = rd_address[i*AW +: AW];
    assign hit = (BYPASS != 0) && wr_eff && (wr_address == ra);
    assign data_out[i*XLEN +: XLEN] = hit ? wr_fmt : storage[ra];
    assign rd_ready[i]              = hit | ~pending[ra];
  end
endmodule

// File: tb/tb_register_file_scoreboard.sv
// Scoreboard bench: stimulus queues expected values, a monitor compares them on demand.
module tb_register_file_scoreboard;
  import register_file_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT A: XLEN=32, NRD=2, BYPASS=1
  logic [9:0]  a_rd;
  logic [63:0] a_do;
  logic [1:0]  a_rdy;
  logic        a_re, a_we;
  logic [4:0]  a_ra, a_wa;
  logic [31:0] a_wd;
  logic [2:0]  a_wp;
  logic [5:0]  a_cnt;

  // DUT B: XLEN=64, NRD=3, BYPASS=0
  logic [14:0]  b_rd;
  logic [191:0] b_do;
  logic [2:0]   b_rdy;
  logic         b_re, b_we;
  logic [4:0]   b_ra, b_wa;
  logic [63:0]  b_wd;
  logic [2:0]   b_wp;
  logic [5:0]   b_cnt;

  register_file_scoreboard #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .rd_address(a_rd), .data_out(a_do), .rd_ready(a_rdy),
    .reserve_enable(a_re), .reserve_address(a_ra), .wr_enable(a_we), .wr_address(a_wa),
    .wr_data(a_wd), .write_pattern(a_wp), .pending_count(a_cnt));

  register_file_scoreboard #(.XLEN(64), .NREGS(32), .NRD(3), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .rd_address(b_rd), .data_out(b_do), .rd_ready(b_rdy),
    .reserve_enable(b_re), .reserve_address(b_ra), .wr_enable(b_we), .wr_address(b_wa),
    .wr_data(b_wd), .write_pattern(b_wp), .pending_count(b_cnt));

  localparam int K_DATA = 0, K_RDY = 1, K_CNT = 2;

  typedef struct {
    string       name;
    int          dut;
    int          kind;
    int          port;
    logic [63:0] v;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  event sample_ev;

  function automatic logic [63:0] actual(int dut, int kind, int port);
    logic [63:0] r;
    r = '0;
    if (dut == 0) begin
      case (kind)
        K_DATA:  r = {32'h0, a_do[port*32 +: 32]};
        K_RDY:   r = {63'h0, a_rdy[port]};
        default: r = {58'h0, a_cnt};
      endcase
    end else begin
      case (kind)
        K_DATA:  r = b_do[port*64 +: 64];
        K_RDY:   r = {63'h0, b_rdy[port]};
        default: r = {58'h0, b_cnt};
      endcase
    end
    return r;
  endfunction

  // Monitor: drains every queued expectation against live DUT outputs.
  initial begin
    forever begin
      @(sample_ev);
      while (q.size() > 0) begin
        exp_t e;
        logic [63:0] act;
        e   = q.pop_front();
        act = actual(e.dut, e.kind, e.port);
        n_checks++;
        if (act !== e.v) begin
          n_fail++;
          $display("FAIL %s: actual %h required %h", e.name, act, e.v);
        end
      end
    end
  end

  task automatic expect_v(string n, int dut, int kind, int port, logic [63:0] v);
    exp_t e;
    e.name = n; e.dut = dut; e.kind = kind; e.port = port; e.v = v;
    q.push_back(e);
  endtask

  task automatic check_now();
    #1;
    ->sample_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    a_re = 0; a_we = 0; a_ra = 0; a_wa = 0; a_wd = 0; a_wp = REGISTER_WRITE_WORD;
    b_re = 0; b_we = 0; b_ra = 0; b_wa = 0; b_wd = 0; b_wp = REGISTER_WRITE_WORD;
  endtask

  task automatic set_rd(input logic [4:0] p0, input logic [4:0] p1);
    a_rd = {p1, p0};
  endtask

  task automatic wr_a(input logic [4:0] ad, input logic [31:0] d, input logic [2:0] p);
    a_we = 1; a_wa = ad; a_wd = d; a_wp = p;
    tick();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1;
    idle();
    a_rd = '0;
    b_rd = '0;
    repeat (2) @(negedge clk);
    expect_v("reset_data", 0, K_DATA, 0, 64'h0);
    expect_v("reset_rdy0", 0, K_RDY, 0, 64'h1);
    expect_v("reset_rdy1", 0, K_RDY, 1, 64'h1);
    expect_v("reset_cnt", 0, K_CNT, 0, 64'h0);
    check_now();
    reset = 0;

    // Write x10 and reserve x20, then reset between edges.
    a_we = 1; a_wa = 10; a_wd = 32'hABCDEFAB; a_re = 1; a_ra = 20; set_rd(10, 20);
    tick(); idle();
    expect_v("x10_written", 0, K_DATA, 0, 64'hABCDEFAB);
    expect_v("x20_pending", 0, K_RDY, 1, 64'h0);
    expect_v("cnt_one", 0, K_CNT, 0, 64'h1);
    check_now();
    a_we = 1; a_wa = 11; a_wd = 32'h5; a_re = 1; a_ra = 12;
    #1 reset = 1;
    expect_v("midrst_data", 0, K_DATA, 0, 64'h0);
    expect_v("midrst_rdy", 0, K_RDY, 1, 64'h1);
    expect_v("midrst_cnt", 0, K_CNT, 0, 64'h0);
    check_now();
    tick();
    reset = 0; idle(); set_rd(11, 12);
    expect_v("rst_discard_wr", 0, K_DATA, 0, 64'h0);
    expect_v("rst_discard_rsv", 0, K_RDY, 1, 64'h1);
    expect_v("rst_discard_cnt", 0, K_CNT, 0, 64'h0);
    check_now();

    // x0 is immutable and never pending.
    a_we = 1; a_wa = 0; a_wd = 32'hEEEEEEEE; a_re = 1; a_ra = 0; set_rd(0, 0);
    expect_v("x0_no_bypass", 0, K_DATA, 0, 64'h0);
    expect_v("x0_rdy_cycle", 0, K_RDY, 0, 64'h1);
    check_now();
    tick(); idle();
    expect_v("x0_data", 0, K_DATA, 1, 64'h0);
    expect_v("x0_rdy", 0, K_RDY, 1, 64'h1);
    expect_v("x0_cnt", 0, K_CNT, 0, 64'h0);
    check_now();

    // Reserve x5, then bypass its writeback.
    a_re = 1; a_ra = 5; set_rd(0, 5);
    tick(); idle();
    expect_v("x5_pending", 0, K_RDY, 1, 64'h0);
    expect_v("x5_cnt1", 0, K_CNT, 0, 64'h1);
    check_now();
    a_we = 1; a_wa = 5; a_wd = 32'h12345678; a_wp = REGISTER_WRITE_WORD;
    expect_v("x5_bypass_data", 0, K_DATA, 1, 64'h12345678);
    expect_v("x5_bypass_rdy", 0, K_RDY, 1, 64'h1);
    expect_v("x5_cnt_before_edge", 0, K_CNT, 0, 64'h1);
    check_now();
    tick(); idle();
    expect_v("x5_cnt0", 0, K_CNT, 0, 64'h0);
    expect_v("x5_stored", 0, K_DATA, 1, 64'h12345678);
    check_now();

    // Write formatting on x15.
    set_rd(15, 15);
    wr_a(15, 32'hABCDEFFA, REGISTER_WRITE_BYTE_UNSIGNED);
    expect_v("byte_u", 0, K_DATA, 0, 64'h000000FA);
    check_now();
    wr_a(15, 32'hABCDEFFA, REGISTER_WRITE_BYTE_SIGNED);
    expect_v("byte_s", 0, K_DATA, 0, 64'hFFFFFFFA);
    check_now();
    wr_a(15, 32'h00008001, REGISTER_WRITE_HALF_SIGNED);
    expect_v("half_s", 0, K_DATA, 0, 64'hFFFF8001);
    check_now();
    wr_a(15, 32'hFFFF8001, REGISTER_WRITE_HALF_UNSIGNED);
    expect_v("half_u", 0, K_DATA, 0, 64'h00008001);
    check_now();
    a_re = 1; a_ra = 15;
    tick(); idle();
    expect_v("x15_pending", 0, K_RDY, 0, 64'h0);
    expect_v("x15_cnt1", 0, K_CNT, 0, 64'h1);
    check_now();
    a_we = 1; a_wa = 15; a_wd = 32'h11111111; a_wp = 3'd7;
    expect_v("illegal_no_bypass", 0, K_DATA, 1, 64'h00008001);
    expect_v("illegal_rdy_cycle", 0, K_RDY, 1, 64'h0);
    check_now();
    tick(); idle();
    expect_v("illegal_unchanged", 0, K_DATA, 0, 64'h00008001);
    expect_v("illegal_still_pend", 0, K_RDY, 0, 64'h0);
    expect_v("illegal_cnt", 0, K_CNT, 0, 64'h1);
    check_now();
    wr_a(15, 32'hCAFEF00D, REGISTER_WRITE_WORD);
    expect_v("x15_word", 0, K_DATA, 0, 64'hCAFEF00D);
    expect_v("x15_clear", 0, K_RDY, 0, 64'h1);
    expect_v("x15_cnt0", 0, K_CNT, 0, 64'h0);
    check_now();

    // Simultaneous reserve and write.
    a_re = 1; a_ra = 7; set_rd(7, 8);
    tick(); idle();
    expect_v("x7_pending", 0, K_RDY, 0, 64'h0);
    expect_v("x7_cnt1", 0, K_CNT, 0, 64'h1);
    check_now();
    a_we = 1; a_wa = 7; a_wd = 32'h77777777; a_re = 1; a_ra = 7;
    tick(); idle();
    expect_v("same_addr_data", 0, K_DATA, 0, 64'h77777777);
    expect_v("same_addr_pend", 0, K_RDY, 0, 64'h0);
    expect_v("same_addr_cnt", 0, K_CNT, 0, 64'h1);
    check_now();
    a_we = 1; a_wa = 7; a_wd = 32'h70707070; a_re = 1; a_ra = 8;
    tick(); idle();
    expect_v("diff_addr_data", 0, K_DATA, 0, 64'h70707070);
    expect_v("diff_addr_x7_clr", 0, K_RDY, 0, 64'h1);
    expect_v("diff_addr_x8_pend", 0, K_RDY, 1, 64'h0);
    expect_v("diff_addr_cnt", 0, K_CNT, 0, 64'h1);
    check_now();
    a_re = 1; a_ra = 8;
    tick(); idle();
    expect_v("rereserve_pend", 0, K_RDY, 1, 64'h0);
    expect_v("rereserve_cnt", 0, K_CNT, 0, 64'h1);
    check_now();
    wr_a(8, 32'h00000088, REGISTER_WRITE_WORD);
    expect_v("x8_clear", 0, K_RDY, 1, 64'h1);
    expect_v("x8_cnt0", 0, K_CNT, 0, 64'h0);
    check_now();

    // DUT B: no bypass, three ports on x3.
    b_rd = {5'd3, 5'd3, 5'd3};
    b_we = 1; b_wa = 3; b_wd = 64'h0123456789ABCDEF; b_wp = REGISTER_WRITE_WORD;
    for (int p = 0; p < 3; p++) expect_v($sformatf("b_old0_p%0d", p), 1, K_DATA, p, 64'h0);
    check_now();
    tick(); idle();
    for (int p = 0; p < 3; p++) expect_v($sformatf("b_new1_p%0d", p), 1, K_DATA, p, 64'h0123456789ABCDEF);
    check_now();
    b_we = 1; b_wa = 3; b_wd = 64'hFEDCBA9876543210; b_wp = REGISTER_WRITE_WORD;
    for (int p = 0; p < 3; p++) expect_v($sformatf("b_old1_p%0d", p), 1, K_DATA, p, 64'h0123456789ABCDEF);
    check_now();
    tick(); idle();
    for (int p = 0; p < 3; p++) expect_v($sformatf("b_new2_p%0d", p), 1, K_DATA, p, 64'hFEDCBA9876543210);
    expect_v("b_rdy2", 1, K_RDY, 2, 64'h1);
    expect_v("b_cnt", 1, K_CNT, 0, 64'h0);
    check_now();

    #5;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: actual %0d left required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
